// File: rtl/dmem_arb_pkg.sv
// Shared types and the alignment rule for the data-memory arbiter.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_e;

    // The reserved size encoding 2'b11 is reported as misaligned.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return addr_lo[0];
            SIZE_WORD: return |addr_lo;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_picker.sv
// Grant picker: round-robin starting after last_grant, or lowest-index-wins
// fixed priority when DMEM_ARB_FIXED_PRIO_EN is defined.
module rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                grant_idx = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        int   cand;
        logic found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_grant) + i) % NUM_REQ;
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = IDX_W'(cand);
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: NUM_REQ requesters share one dmemory port through an
// IDLE/ACCESS/RESP sequence with a registered response.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ-1:0][1:0]        req_size,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_W-1:0]              rsp_rdata,
    output logic                           rsp_err,
    output logic                           mem_we,
    output logic [1:0]                     mem_size,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_wdata,
    input  logic [DATA_W-1:0]              mem_rdata
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e              state, state_next;
    logic [IDX_W-1:0]    last_grant, grant_idx, owner_p0;
    logic [NUM_REQ-1:0]  grant;
    logic                handshake, mis_p0;
    logic                we_p0, err_p1;
    size_e               size_p0;
    logic [ADDR_W-1:0]   addr_p0;
    logic [DATA_W-1:0]   wdata_p0, rdata_p1;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign handshake = |(req_valid & req_ready);
    assign mis_p0    = is_misaligned(size_p0, addr_p0[1:0]);
    assign mem_size  = size_p0;
    assign mem_addr  = addr_p0;
    assign mem_wdata = wdata_p0;
    assign rsp_rdata = rdata_p1;
    assign rsp_err   = err_p1;

    // The slot reopens in RESP so a new request can overlap the response cycle.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        rsp_valid  = '0;
        mem_we     = 1'b0;
        case (state)
            IDLE: begin
                if (reset) req_ready = grant;
                if (handshake) state_next = ACCESS;
            end
            ACCESS: begin
                mem_we     = we_p0 & ~mis_p0;
                state_next = RESP;
            end
            RESP: begin
                if (reset) req_ready = grant;
                rsp_valid[owner_p0] = 1'b1;
                state_next = handshake ? ACCESS : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            owner_p0   <= '0;
            we_p0      <= 1'b0;
            size_p0    <= SIZE_BYTE;
            addr_p0    <= '0;
            wdata_p0   <= '0;
            rdata_p1   <= '0;
            err_p1     <= 1'b0;
        end else begin
            state <= state_next;
            // p0: capture the winning request
            if (handshake) begin
                last_grant <= grant_idx;
                owner_p0   <= grant_idx;
                we_p0      <= req_we[grant_idx];
                size_p0    <= size_e'(req_size[grant_idx]);
                addr_p0    <= req_addr[grant_idx];
                wdata_p0   <= req_wdata[grant_idx];
            end
            // p1: register the memory result for the response cycle
            if (state == ACCESS) begin
                err_p1   <= mis_p0;
                rdata_p1 <= (we_p0 || mis_p0) ? '0 : mem_rdata;
            end
        end
    end

endmodule
